// File: rtl/clock_monitor.sv
// clock_monitor: measures the period of an asynchronous mon_clk in clk cycles,
// reports each measurement, flags periods outside [MIN_CYCLES, MAX_CYCLES]
// and flags a mon_clk that has stopped for TIMEOUT clk cycles.
// Optional high-phase measurement on high_cnt: define CLOCK_MONITOR_DUTY_EN.
`timescale 1ns/1ps
module clock_monitor #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_CYCLES = 4,
  parameter int unsigned MAX_CYCLES = 6,
  parameter int unsigned TIMEOUT    = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mon_clk,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             stopped,
  output logic             err_period,
  output logic             err_stop,
  output logic [CNT_W-1:0] high_cnt
);

  if (MIN_CYCLES < 2 || MIN_CYCLES > MAX_CYCLES || MAX_CYCLES >= TIMEOUT ||
      64'(TIMEOUT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_param_check
    $error("clock_monitor: illegal parameter set");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_CYCLES);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sync_q, sync_d;     // [0]=s1, [1]=s2, [2]=s3
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             err_period_q, err_period_d;
  logic             err_stop_q, err_stop_d;
  logic             rise;

  assign rise    = sync_q[1] & ~sync_q[2];
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  // Next-state, measurement and sticky-flag logic
  always_comb begin
    sync_d         = {sync_q[1:0], mon_clk};
    state_d        = state_q;
    cnt_d          = cnt_inc;
    period_d       = period_q;
    period_valid_d = 1'b0;
    err_period_d   = err_period_q & ~clear;
    err_stop_d     = err_stop_q & ~clear;
    if (!enable) begin
      state_d = ACQUIRE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ACQUIRE: begin
          if (rise) begin
            state_d = RUN;
            cnt_d   = CNT_ONE;
          end
        end
        RUN: begin
          // A rise coinciding with cnt == TIMEOUT is a normal (late) report
          if (rise) begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            cnt_d          = CNT_ONE;
            if (cnt_q < MIN_C || cnt_q > MAX_C) err_period_d = 1'b1;
          end else if (cnt_q == TMO_C) begin
            state_d    = STOPPED;
            err_stop_d = 1'b1;
          end
        end
        STOPPED: begin
          if (rise) begin
            state_d = RUN;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: state_d = ACQUIRE;
      endcase
    end
  end

  // State, synchronizer and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ACQUIRE;
      sync_q         <= '0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      err_period_q   <= 1'b0;
      err_stop_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      err_period_q   <= err_period_d;
      err_stop_q     <= err_stop_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign stopped      = (state_q == STOPPED);
  assign err_period   = err_period_q;
  assign err_stop     = err_stop_q;

`ifdef CLOCK_MONITOR_DUTY_EN
  logic             fall;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;

  assign fall = ~sync_q[1] & sync_q[2];

  // High-phase counter; a rise always restarts it since every rise leads to RUN
  always_comb begin
    hcnt_d     = hcnt_q;
    high_cnt_d = high_cnt_q;
    if (enable) begin
      if (rise) begin
        hcnt_d = CNT_ONE;
      end else if (state_q == RUN) begin
        if (sync_q[1] && hcnt_q != CNT_MAX) hcnt_d = hcnt_q + CNT_ONE;
        if (fall) high_cnt_d = hcnt_q;
      end
    end
  end

  // High-phase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q     <= '0;
      high_cnt_q <= '0;
    end else begin
      hcnt_q     <= hcnt_d;
      high_cnt_q <= high_cnt_d;
    end
  end

  assign high_cnt = high_cnt_q;
`else
  assign high_cnt = '0;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: directed scoreboard bench for clock_monitor.
// mon_clk edges are placed 2 ns after a clk rising edge so every period is an
// exact number of clk cycles. Define CLOCK_MONITOR_DUTY_EN to check high_cnt.
`timescale 1ns/1ps
module tb_clock_monitor;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned MIN_C = 5;
  localparam int unsigned MAX_C = 7;
  localparam int unsigned TMO   = 20;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             mon_clk = 1'b0;
  logic             enable  = 1'b0;
  logic             clear   = 1'b0;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             stopped;
  logic             err_period;
  logic             err_stop;
  logic [CNT_W-1:0] high_cnt;

  clock_monitor #(
    .CNT_W      (CNT_W),
    .MIN_CYCLES (MIN_C),
    .MAX_CYCLES (MAX_C),
    .TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mon_clk      (mon_clk),
    .enable       (enable),
    .clear        (clear),
    .period       (period),
    .period_valid (period_valid),
    .stopped      (stopped),
    .err_period   (err_period),
    .err_stop     (err_stop),
    .high_cnt     (high_cnt)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int unsigned per;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec     = 0;
  int   n_err     = 0;
  bit   armed     = 1'b0;
  bit   tb_en     = 1'b0;
  bit   err_model = 1'b0;
  time  last_rise = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Record a mon_clk rise: the rise reports the time since the previous one.
  task automatic note_rise(input bit clr_coll);
    int unsigned p;
    bit          oow;
    if (tb_en) begin
      if (armed) begin
        p         = int'(($time - last_rise) / 10);
        oow       = (p < MIN_C) || (p > MAX_C);
        err_model = clr_coll ? oow : (err_model | oow);
        exp_q.push_back('{per: p, err: err_model});
      end
      armed     = 1'b1;
      last_rise = $time;
    end else begin
      armed = 1'b0;
    end
  endtask

  // One mon_clk cycle; clr_coll pulses clear exactly on the report update edge.
  task automatic mon_cycle(input int hi, input int lo, input bit clr_coll);
    mon_clk = 1'b1;
    note_rise(clr_coll);
    if (clr_coll) begin
      #20 clear = 1'b1;
      #10 clear = 1'b0;
      #(hi - 30);
    end else begin
      #(hi);
    end
    mon_clk = 1'b0;
    #(lo);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #10 clear = 1'b0;
    err_model = 1'b0;
  endtask

  task automatic check_high(input int unsigned exp_high);
`ifdef CLOCK_MONITOR_DUTY_EN
    check("high_cnt", high_cnt, exp_high);
`else
    check("high_cnt_tied", high_cnt, 0);
    if (exp_high == 0) check("high_cnt_tied_zero", high_cnt, 0);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, period, 0);
    check({tag, "_period_valid"}, period_valid, 0);
    check({tag, "_stopped"}, stopped, 0);
    check({tag, "_err_period"}, err_period, 0);
    check({tag, "_err_stop"}, err_stop, 0);
    check({tag, "_high_cnt"}, high_cnt, 0);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && period_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid: period_valid with period %0d, none expected at %0t",
                   period, $time);
        end else begin
          e = exp_q.pop_front();
          check("period", period, e.per);
          check("err_period_at_valid", err_period, e.err);
          check("stopped_at_valid", stopped, 0);
        end
      end
    end
  endtask

  task automatic stimulus();
    // Reset state
    #22;
    check_all_zero("reset");
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    enable = 1'b1;
    tb_en  = 1'b1;
    #10;

    // Steady 60 ns clock: reports 6 from the second rise on
    repeat (4) mon_cycle(30, 30, 1'b0);
    check("steady_period", period, 6);
    check("steady_err_period", err_period, 0);
    check("steady_err_stop", err_stop, 0);
    check("steady_stopped", stopped, 0);
    check_high(3);

    // Window edges 5 and 7 are legal
    mon_cycle(30, 20, 1'b0);
    mon_cycle(40, 30, 1'b0);
    check_high(4);
    mon_cycle(30, 30, 1'b0);
    check("edge_period_7", period, 7);
    check("edge_err_period", err_period, 0);

    // Out of window at 100 ns, back to 60 ns keeps the sticky flag
    repeat (3) mon_cycle(50, 50, 1'b0);
    check("slow_period", period, 10);
    check("slow_err_period", err_period, 1);
    repeat (2) mon_cycle(30, 30, 1'b0);
    check("back_period", period, 6);
    check("back_err_sticky", err_period, 1);
    do_clear();
    check("cleared_err_period", err_period, 0);

    // Period of 4 is below the window
    mon_cycle(20, 20, 1'b0);
    mon_cycle(30, 30, 1'b0);
    mon_cycle(30, 30, 1'b0);
    check("short_err_period", err_period, 1);

    // Period of exactly TIMEOUT: the rise wins, late report, no stop
    mon_cycle(100, 100, 1'b0);
    mon_cycle(30, 30, 1'b0);
    check("tmo_edge_period", period, 20);
    check("tmo_edge_stopped", stopped, 0);
    check("tmo_edge_err_stop", err_stop, 0);

    // Halt: stop declared TIMEOUT cycles after the last rise, no reports
    mon_cycle(30, 30, 1'b0);
    #140;
    check("halt_not_yet_stopped", stopped, 0);
    #60;
    check("halt_stopped", stopped, 1);
    check("halt_err_stop", err_stop, 1);
    armed = 1'b0;
    mon_cycle(30, 30, 1'b0);
    check("restart_stopped", stopped, 0);
    check("restart_err_stop_sticky", err_stop, 1);
    repeat (2) mon_cycle(30, 30, 1'b0);
    check("restart_period", period, 6);

    // Asynchronous reset in the middle of a mon_clk period
    mon_clk = 1'b1;
    note_rise(1'b0);
    #30 mon_clk = 1'b0;
    #20;
    check("pre_reset_period", period, 6);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    #9;
    rst_n     = 1'b1;
    armed     = 1'b0;
    err_model = 1'b0;
    mon_cycle(30, 30, 1'b0);
    mon_cycle(20, 20, 1'b0);
    mon_cycle(30, 30, 1'b0);
    check("post_reset_period", period, 4);
    check("post_reset_err_period", err_period, 1);

    // Enable low for 10 cycles: no reports, outputs held
    enable = 1'b0;
    tb_en  = 1'b0;
    mon_cycle(30, 30, 1'b0);
    mon_cycle(20, 20, 1'b0);
    check("disabled_period_held", period, 4);
    check("disabled_err_held", err_period, 1);
    check("disabled_stopped", stopped, 0);
    enable = 1'b1;
    tb_en  = 1'b1;
    repeat (3) mon_cycle(30, 30, 1'b0);
    check("reenable_period", period, 6);

    // Clear in the same cycle as an out-of-window update: set wins
    do_clear();
    mon_cycle(30, 30, 1'b0);
    mon_cycle(50, 50, 1'b0);
    check("pre_collision_err", err_period, 0);
    mon_cycle(30, 30, 1'b1);
    check("collision_period", period, 10);
    check("collision_err_period", err_period, 1);
    mon_cycle(30, 30, 1'b0);

    #100;
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    fork
      monitor_loop();
      stimulus();
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
